uart_rx_ctrl: RTL
=================

# uart_rx_ctrl

Receive-side controller for the AHB UART peripheral. It sits between the `uart_rx` frame receiver and the AHB register slave. It buffers received bytes in a parameterised FIFO and drives back-pressure (`rx_full_o`) to the receiver. It exposes a first-word-fall-through pop port, occupancy/status and a sticky overrun flag to the register block, and raises a level interrupt from a programmable threshold, overrun, and an optional idle timeout.

## Interface
- `DEPTH`, 8: FIFO entries; must be a power of two, ≥ 2.
- `AW`, 3: log2(`DEPTH`).
- `TIMEOUT`, 352: idle-timeout length in `clk` cycles (4 frames at the 8× oversample clock); 16-bit range, ≥ 1.
- `clk` input 1: clock clk, shared with `uart_rx` (8× baud).
- `rst_n` input 1: reset rst_n, asynchronous, active-low.
- `rx_data_i` input 8: received byte; only meaningful while `rx_we_i`=1.
- `rx_we_i` input 1: single-cycle write strobe from the receiver.
- `rx_full_o` output 1: FIFO full; the receiver ignores new start bits while it is high.
- `rd_en_i` input 1: pop the head entry (one per cycle).
- `rd_data_o` output 8: head entry; 8'h00 while empty.
- `empty_o` output 1: FIFO empty.
- `count_o` output AW+1: current occupancy, 0..`DEPTH`.
- `thr_i` input AW+1: interrupt threshold; 0 disables the level interrupt.
- `clr_ovr_i` input 1: clears the sticky overrun flag.
- `ovr_o` output 1: sticky overrun flag.
- `irq_o` output 1: registered interrupt request.

## Operation
- **Storage:**
  - `DEPTH`×8 register array.
  - Write pointer and read pointer are AW bits and wrap modulo `DEPTH`.
  - Occupancy is an (AW+1)-bit counter; all three are registered.
- **Push:** accepted when `rx_we_i`=1 and either `count_o` < `DEPTH`, or `count_o` = `DEPTH` and a pop is accepted in the same cycle.
- **Overrun:** `rx_we_i`=1 with `count_o` = `DEPTH` and no pop → byte dropped, `ovr_o` set.
- **Pop:** accepted when `rd_en_i`=1 and `count_o` > 0. `rd_en_i` while empty is ignored: no pointer or count change, no error.
- **Simultaneous push and pop:**
  - Both take effect and `count_o` is unchanged.
  - When empty, the push happens and the pop is ignored, so `count_o` becomes 1.
- **Overrun flag:** `clr_ovr_i` clears `ovr_o`. If a clear and a new overrun occur in the same cycle, set wins.
- **Combinational status from registered state:**
  - `rx_full_o` = (`count_o` = `DEPTH`).
  - `empty_o` = (`count_o` = 0).
  - `rd_data_o` = mem[rd_ptr] when not empty, else 0.
- **Interrupt sources:**
  - `lvl` = (`thr_i` ≠ 0) && (`count_o` ≥ `thr_i`).
  - `ovr_o`.
  - `tmo` (see Configuration).
  - `irq_o` is registered: `irq_o` <= `lvl` | `ovr_o` | `tmo`.
- `thr_i` > `DEPTH` never satisfies `lvl`.
- **Reset mid-operation:**
  - Pointers, count, `ovr_o`, timeout state and `irq_o` clear immediately.
  - FIFO contents are discarded. The array itself need not be reset, but `rd_data_o` reads 0 because the FIFO is empty.

## Timing
- **Reset values:**
  - `rx_full_o`=0, `empty_o`=1, `count_o`=0, `rd_data_o`=0, `ovr_o`=0, `irq_o`=0.
- **Push latency:** the byte written at edge N is visible on `rd_data_o`, with `count_o`/`empty_o` updated, after edge N.
- **Pop:** the head advances at the edge where `rd_en_i`=1, and the next entry (or 0) is visible after that edge.
- **Full:**
  - `rx_full_o` rises after the edge that makes count = `DEPTH`.
  - It falls after the first accepted pop, unless that pop coincides with a push.
- `ovr_o` sets after the dropping edge.
- `irq_o` lags its sources by one cycle, so it asserts 2 cycles after the causing push or overrun strobe.
- Back-to-back pops at 1/cycle are supported; a full drain of `DEPTH` entries takes `DEPTH` cycles.

## Configuration
- **`UART_RX_TIMEOUT_EN` defined:**
  - A 16-bit idle counter resets to 0 on any accepted push or pop, or while empty.
  - Otherwise it increments, saturating at `TIMEOUT`.
  - `tmo` = (counter = `TIMEOUT`) && !`empty_o`; it stays high until a push, a pop or reset.
  - Lets software collect short messages that stay below `thr_i`.
- **Not defined:** counter logic absent; `tmo` is constant 0 and all other behaviour is identical.

## Test plan
- **Reset:** assert `rst_n`=0 mid-traffic with count=5 → next cycle `count_o`=0, `empty_o`=1, `rd_data_o`=0, `irq_o`=0, `ovr_o`=0.
- **Order and wrap:** push 0x11..0x18 (`DEPTH`=8) with no pop → `rx_full_o`=1, `count_o`=8. Pop 8 → data returns 0x11..0x18 in order, `empty_o`=1. Repeat 3 times across pointer wrap.
- **Overrun:** with FIFO full, push 0xAA → `ovr_o`=1 and 0xAA never appears. Push+pop in the same cycle when full → `count_o` stays 8 and no overrun. `clr_ovr_i` coincident with a new overrun → `ovr_o` stays 1.
- **Threshold:**
  - `thr_i`=3: push 2 → `irq_o`=0; third push → `irq_o`=1 two cycles after the strobe.
  - Pop 1 → `irq_o`=0.
  - `thr_i`=0 with full FIFO → `irq_o`=0 (no overrun).
- **Empty and simultaneous:** `rd_en_i` while empty → no state change. Push+pop while empty → `count_o`=1 and `rd_data_o` = pushed byte.
- **Timeout (with `UART_RX_TIMEOUT_EN`, `TIMEOUT`=352):** push 1 byte, idle → `irq_o`=1 exactly 352+1 cycles after the push settles. A pop drops it next cycle. Without the macro, `irq_o` stays 0.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive FIFO between uart_rx and the AHB register slave.
// Buffers received bytes, back-pressures the receiver when full, exposes a
// first-word-fall-through pop port, a sticky overrun flag and a level IRQ
// from threshold, overrun and (optionally) idle timeout.
// Optional feature macro: UART_RX_TIMEOUT_EN (idle-timeout interrupt source).
module uart_rx_ctrl #(
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned AW      = 3,
   parameter int unsigned TIMEOUT = 352
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [7:0]    rx_data_i,
   input  logic          rx_we_i,
   output logic          rx_full_o,
   input  logic          rd_en_i,
   output logic [7:0]    rd_data_o,
   output logic          empty_o,
   output logic [AW:0]   count_o,
   input  logic [AW:0]   thr_i,
   input  logic          clr_ovr_i,
   output logic          ovr_o,
   output logic          irq_o
);

   localparam int unsigned CW = AW + 1;

   // Reject configurations the pointer/count arithmetic cannot support
   if (DEPTH < 2 || DEPTH != (32'd1 << AW) || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
      $error("uart_rx_ctrl: DEPTH must be 2**AW and >= 2, TIMEOUT in 1..65535");
   end

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_ovr;
   logic          r_irq;

   logic          w_full;
   logic          w_empty;
   logic          w_pop;
   logic          w_push;
   logic          w_drop;
   logic          w_lvl;
   logic          w_tmo;

   // Accept/drop decisions; a pop frees the slot a same-cycle push needs when full
   always_comb begin
      w_full  = (r_count == CW'(DEPTH));
      w_empty = (r_count == '0);
      w_pop   = rd_en_i && !w_empty;
      w_push  = rx_we_i && (!w_full || w_pop);
      w_drop  = rx_we_i && w_full && !w_pop;
      w_lvl   = (thr_i != '0) && (r_count >= thr_i);
   end

   // Storage array; contents are don't-care once the pointers say empty
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= rx_data_i;
   end

   // Pointers and occupancy; pointers wrap naturally since DEPTH is 2**AW
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   // Sticky overrun flag; a new overrun beats a coincident clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         r_ovr <= 1'b0;
      else if (w_drop)    r_ovr <= 1'b1;
      else if (clr_ovr_i) r_ovr <= 1'b0;
   end

`ifdef UART_RX_TIMEOUT_EN
   logic [15:0] r_idle;

   // Idle counter: restarts on any traffic or while empty, saturates at TIMEOUT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                           r_idle <= '0;
      else if (w_push || w_pop || w_empty)  r_idle <= '0;
      else if (r_idle != 16'(TIMEOUT))      r_idle <= r_idle + 16'd1;
   end

   assign w_tmo = (r_idle == 16'(TIMEOUT)) && !w_empty;
`else
   assign w_tmo = 1'b0;
`endif

   // Registered interrupt request, one cycle behind its sources
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_irq <= 1'b0;
      else        r_irq <= w_lvl || r_ovr || w_tmo;
   end

   assign rx_full_o = w_full;
   assign empty_o   = w_empty;
   assign count_o   = r_count;
   assign rd_data_o = w_empty ? 8'h00 : r_mem[r_rd_ptr];
   assign ovr_o     = r_ovr;
   assign irq_o     = r_irq;

endmodule
